// File: rtl/mouse_pos_tracker_pkg.sv
// Shared constants, PS/2 byte0 bit map and FSM state type for the mouse position tracker.
package mouse_pos_tracker_pkg;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int POS_W    = 10;
   localparam int DELTA_W  = 9;
   localparam int ARITH_W  = 12;

   localparam int BTN_L   = 0;
   localparam int BTN_R   = 1;
   localparam int BTN_M   = 2;
   localparam int ALWAYS1 = 3;
   localparam int XSIGN   = 4;
   localparam int YSIGN   = 5;
   localparam int XOVF    = 6;
   localparam int YOVF    = 7;

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      WAIT_B1 = 2'd1,
      WAIT_B2 = 2'd2,
      UPDATE  = 2'd3
   } rx_state_t;

   // Widen a 9-bit two's-complement delta to the arithmetic width.
   function automatic logic signed [ARITH_W-1:0] sext_delta(input logic [DELTA_W-1:0] d);
      return {{(ARITH_W-DELTA_W){d[DELTA_W-1]}}, d};
   endfunction
endpackage

// File: rtl/mouse_pos_tracker_axis_sat_add.sv
// One cursor axis: adds (or subtracts) a signed delta and clamps the result to 0..max.
module axis_sat_add
   import mouse_pos_tracker_pkg::*;
(
   input  logic [POS_W-1:0]          pos,
   input  logic signed [DELTA_W-1:0] delta,
   input  logic                      neg,
   input  logic [POS_W-1:0]          max,
   output logic [POS_W-1:0]          pos_next
);
   logic signed [ARITH_W-1:0] delta_ext_s;
   logic signed [ARITH_W-1:0] pos_ext_s;
   logic signed [ARITH_W-1:0] max_ext_s;
   logic signed [ARITH_W-1:0] sum_s;

   // 12-bit signed sum leaves headroom for 639+255 and 0-256 without wrap.
   always_comb begin
      delta_ext_s = sext_delta(delta);
      pos_ext_s   = $signed({2'b00, pos});
      max_ext_s   = $signed({2'b00, max});
      if (neg) begin
         sum_s = pos_ext_s - delta_ext_s;
      end else begin
         sum_s = pos_ext_s + delta_ext_s;
      end
      if (sum_s < 12'sd0) begin
         pos_next = {POS_W{1'b0}};
      end else if (sum_s > max_ext_s) begin
         pos_next = max;
      end else begin
         pos_next = sum_s[POS_W-1:0];
      end
   end
endmodule

// File: rtl/mouse_pos_tracker.sv
// Assembles 3-byte PS/2 mouse packets and integrates them into a clamped cursor position.
module mouse_pos_tracker
   import mouse_pos_tracker_pkg::*;
#(
   parameter int X_MAX   = SCREEN_W - 1,
   parameter int Y_MAX   = SCREEN_H - 1,
   parameter int X_INIT  = 320,
   parameter int Y_INIT  = 240,
   parameter int TIMEOUT = 2_500_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_done,
   output logic [POS_W-1:0] mouse_x,
   output logic [POS_W-1:0] mouse_y,
   output logic             btn_l,
   output logic             btn_r,
   output logic             btn_m,
   output logic             pkt_valid,
   output logic             sync_err
);
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [POS_W-1:0] X_MAX_V  = POS_W'(X_MAX);
   localparam logic [POS_W-1:0] Y_MAX_V  = POS_W'(Y_MAX);

   rx_state_t          state_r, next_state_s;
   logic [7:0]         byte0_r, byte1_r, byte2_r;
   logic [CNT_W-1:0]   cnt_r, cnt_next_s;
   logic               latch0_s, latch1_s, latch2_s, err_s, commit_s;
   logic [DELTA_W-1:0] dx_s, dy_s;
   logic [POS_W-1:0]   x_next_s, y_next_s;

   assign dx_s = byte0_r[XOVF] ? {DELTA_W{1'b0}} : {byte0_r[XSIGN], byte1_r};
   assign dy_s = byte0_r[YOVF] ? {DELTA_W{1'b0}} : {byte0_r[YSIGN], byte2_r};

   axis_sat_add u_x_axis (
      .pos      (mouse_x),
      .delta    (dx_s),
      .neg      (1'b0),
      .max      (X_MAX_V),
      .pos_next (x_next_s)
   );

   // PS/2 +dy points up, screen +y points down.
   axis_sat_add u_y_axis (
      .pos      (mouse_y),
      .delta    (dy_s),
      .neg      (1'b1),
      .max      (Y_MAX_V),
      .pos_next (y_next_s)
   );

   // Packet FSM next-state and idle-timeout logic; UPDATE also accepts a new byte0.
   always_comb begin
      next_state_s = state_r;
      cnt_next_s   = cnt_r;
      latch0_s     = 1'b0;
      latch1_s     = 1'b0;
      latch2_s     = 1'b0;
      err_s        = 1'b0;
      commit_s     = 1'b0;
      case (state_r)
         WAIT_B0, UPDATE: begin
            commit_s   = (state_r == UPDATE);
            cnt_next_s = {CNT_W{1'b0}};
            if (rx_done) begin
               if (rx_data[ALWAYS1]) begin
                  latch0_s     = 1'b1;
                  next_state_s = WAIT_B1;
               end else begin
                  err_s        = 1'b1;
                  next_state_s = WAIT_B0;
               end
            end else begin
               next_state_s = WAIT_B0;
            end
         end
         WAIT_B1, WAIT_B2: begin
            if (rx_done) begin
               latch1_s     = (state_r == WAIT_B1);
               latch2_s     = (state_r == WAIT_B2);
               cnt_next_s   = {CNT_W{1'b0}};
               next_state_s = (state_r == WAIT_B1) ? WAIT_B2 : UPDATE;
            end else if (cnt_r == CNT_LAST) begin
               err_s        = 1'b1;
               cnt_next_s   = {CNT_W{1'b0}};
               next_state_s = WAIT_B0;
            end else begin
               cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            next_state_s = WAIT_B0;
            cnt_next_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, packet bytes and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= WAIT_B0;
         cnt_r     <= {CNT_W{1'b0}};
         byte0_r   <= 8'h00;
         byte1_r   <= 8'h00;
         byte2_r   <= 8'h00;
         mouse_x   <= POS_W'(X_INIT);
         mouse_y   <= POS_W'(Y_INIT);
         btn_l     <= 1'b0;
         btn_r     <= 1'b0;
         btn_m     <= 1'b0;
         pkt_valid <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         cnt_r     <= cnt_next_s;
         pkt_valid <= commit_s;
         sync_err  <= err_s;
         if (latch0_s) byte0_r <= rx_data;
         if (latch1_s) byte1_r <= rx_data;
         if (latch2_s) byte2_r <= rx_data;
         if (commit_s) begin
            mouse_x <= x_next_s;
            mouse_y <= y_next_s;
            btn_l   <= byte0_r[BTN_L];
            btn_r   <= byte0_r[BTN_R];
            btn_m   <= byte0_r[BTN_M];
         end
      end
   end
endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Directed bench for mouse_pos_tracker with a shortened timeout and hand-computed positions.
module tb_mouse_pos_tracker;
   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic [9:0] mouse_x, mouse_y;
   logic       btn_l, btn_r, btn_m, pkt_valid, sync_err;

   int vectors = 0;
   int miscompares = 0;
   int err_cnt = 0;
   int pv_cnt = 0;
   int err_base, pv_base;

   mouse_pos_tracker #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .mouse_x(mouse_x), .mouse_y(mouse_y), .btn_l(btn_l), .btn_r(btn_r),
      .btn_m(btn_m), .pkt_valid(pkt_valid), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      if (sync_err)  err_cnt <= err_cnt + 1;
      if (pkt_valid) pv_cnt  <= pv_cnt + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] b2b [6];
      b2b[0] = 8'h08; b2b[1] = 8'h01; b2b[2] = 8'h00;
      b2b[3] = 8'h08; b2b[4] = 8'h02; b2b[5] = 8'h00;

      repeat (3) @(negedge clk);
      chk("rst_x", mouse_x, 320);
      chk("rst_y", mouse_y, 240);
      chk("rst_btn", {btn_m, btn_r, btn_l}, 0);
      chk("rst_pv", pkt_valid, 0);
      chk("rst_err", sync_err, 0);
      reset = 1'b0;

      // reset in WAIT_B2 must drop the partial packet
      send_byte(8'h08);
      send_byte(8'h05);
      do_reset();
      chk("midrst_x", mouse_x, 320);
      chk("midrst_y", mouse_y, 240);

      pv_base = pv_cnt;
      send_byte(8'h08);
      send_byte(8'h05);
      send_byte(8'h03);
      chk("lat_x_hold", mouse_x, 320);
      chk("lat_pv_low", pkt_valid, 0);
      @(negedge clk);
      chk("pkt_x", mouse_x, 325);
      chk("pkt_y", mouse_y, 237);
      chk("pkt_pv_hi", pkt_valid, 1);
      @(negedge clk);
      chk("pkt_pv_lo", pkt_valid, 0);
      chk("pkt_x_hold", mouse_x, 325);
      chk("pkt_pv_cnt", pv_cnt - pv_base, 1);

      // saturation at both ends of x
      do_reset();
      send_pkt(8'h18, 8'h00, 8'h00);
      chk("neg1_x", mouse_x, 64);
      send_pkt(8'h18, 8'h00, 8'h00);
      chk("neg2_x", mouse_x, 0);
      send_pkt(8'h18, 8'h00, 8'h00);
      chk("neg3_x_floor", mouse_x, 0);
      chk("neg_y", mouse_y, 240);
      send_pkt(8'h08, 8'hFF, 8'h00);
      chk("pos1_x", mouse_x, 255);
      send_pkt(8'h08, 8'hFF, 8'h00);
      chk("pos2_x", mouse_x, 510);
      send_pkt(8'h08, 8'hFF, 8'h00);
      chk("pos3_x_sat", mouse_x, 639);
      send_pkt(8'h08, 8'h01, 8'h00);
      chk("max_plus1_x", mouse_x, 639);

      // bad byte0 rejected, following packet parsed
      do_reset();
      send_byte(8'h00);
      chk("bad_b0_err", sync_err, 1);
      send_pkt(8'h08, 8'h01, 8'h01);
      chk("resync_x", mouse_x, 321);
      chk("resync_y", mouse_y, 239);
      chk("resync_err_lo", sync_err, 0);

      // idle timeout mid-packet
      err_base = err_cnt;
      pv_base  = pv_cnt;
      send_byte(8'h08);
      send_byte(8'h10);
      repeat (TMO - 1) @(negedge clk);
      chk("tmo_early", sync_err, 0);
      @(negedge clk);
      chk("tmo_err", sync_err, 1);
      repeat (3) @(negedge clk);
      chk("tmo_err_cnt", err_cnt - err_base, 1);
      chk("tmo_pv_cnt", pv_cnt - pv_base, 0);
      chk("tmo_x", mouse_x, 321);
      chk("tmo_y", mouse_y, 239);
      send_byte(8'h09);
      send_byte(8'h00);
      send_byte(8'h00);
      @(negedge clk);
      chk("tmo_next_pv", pkt_valid, 1);
      chk("tmo_next_btnl", btn_l, 1);
      chk("tmo_next_x", mouse_x, 321);
      chk("tmo_next_y", mouse_y, 239);

      // x overflow bit forces dx to 0
      send_pkt(8'h48, 8'h7F, 8'h01);
      chk("xovf_x", mouse_x, 321);
      chk("xovf_y", mouse_y, 238);
      chk("xovf_btnl", btn_l, 0);

      // byte arriving on the expiry cycle is consumed without error
      err_base = err_cnt;
      send_byte(8'h08);
      repeat (TMO - 2) @(negedge clk);
      send_byte(8'h05);
      send_byte(8'h00);
      @(negedge clk);
      chk("race_x", mouse_x, 326);
      chk("race_err_cnt", err_cnt - err_base, 0);

      // back-to-back strobes: byte0 taken during UPDATE
      pv_base = pv_cnt;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         rx_data = b2b[i];
         rx_done = 1'b1;
         @(negedge clk);
      end
      rx_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("b2b_x", mouse_x, 329);
      chk("b2b_pv_cnt", pv_cnt - pv_base, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
